// File: rtl/sat_addsub_pipe.sv
// -----------------------------------------------------------------------------
// sat_addsub_pipe
//
// Pipelined signed add/subtract with valid/ready handshakes, a signed
// overflow flag and a sticky overflow indicator.
//
// The WIDTH-bit add is split into STAGES carry segments of WIDTH/STAGES bits.
// Stage k adds operand slice k using the registered carry from stage k-1.
// Each stage registers only what later stages still need:
//   - the not-yet-added upper operand slices
//   - the already-computed lower sum slices
// Because of this, every result leaves the pipe self-consistent.
//
// Subtraction is performed as A + ~B with carry-in 1.
//
// Ovfl is the XOR of the carry into and the carry out of the MSB.
//
// Optional feature (macro ADDSUB_SAT_EN):
//   defined   : overflowing results saturate to 0x7FF..F or 0x800..0. The
//               direction is taken from the sign of A.
//   undefined : the wrapped two's-complement result is produced.
// Ovfl and ovfl_sticky behave the same in both builds.
//
// Parameters:
//   WIDTH   operand/result width (multiple of STAGES, >= 4)
//   STAGES  pipeline depth / carry segments (1..4)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand set valid
//   in_ready     operand set accepted this cycle (= advance)
//   A, B         signed operands
//   Sub          0: A+B, 1: A-B
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   Sum          result (registered)
//   Ovfl         signed overflow of the presented result (registered)
//   ovfl_sticky  an overflow result was accepted since the last clear
//   ovfl_clr     synchronous clear of ovfl_sticky (a same-cycle set wins)
// -----------------------------------------------------------------------------
module sat_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             ovfl_sticky,
  input  logic             ovfl_clr
);

  localparam int SW = WIDTH / STAGES;

  logic advance;

  // The whole pipe moves together whenever the output slot is free or
  // being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;      // sum bits already produced upstream
    localparam int HI = WIDTH - LO;  // operand bits still to be added

    logic [HI-1:0]      a_in;
    logic [HI-1:0]      b_in;
    logic               c_in;
    logic               v_in;
    logic [SW:0]        sl;
    logic [LO+SW-1:0]   s_cat;
    logic [LO+SW-1:0]   s_r;
    logic               v_r;

    if (k == 0) begin : g_first
      assign a_in  = A;
      assign b_in  = Sub ? ~B : B;
      assign c_in  = Sub;
      assign v_in  = in_valid;
      assign s_cat = sl[SW-1:0];
    end else begin : g_next
      assign a_in  = g_stage[k-1].g_mid.a_r;
      assign b_in  = g_stage[k-1].g_mid.b_r;
      assign c_in  = g_stage[k-1].g_mid.c_r;
      assign v_in  = g_stage[k-1].v_r;
      assign s_cat = {sl[SW-1:0], g_stage[k-1].s_r};
    end

    // Slice add; sl[SW] is the carry out of this segment.
    assign sl = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_mid
      logic [HI-SW-1:0] a_r;
      logic [HI-SW-1:0] b_r;
      logic             c_r;

      // Intermediate stage register: remaining operand slices, carry, partial sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
          c_r <= 1'b0;
          s_r <= '0;
          v_r <= 1'b0;
        end else if (advance) begin
          a_r <= a_in[HI-1:SW];
          b_r <= b_in[HI-1:SW];
          c_r <= sl[SW];
          s_r <= s_cat;
          v_r <= v_in;
        end
      end
    end else begin : g_last
      logic             ov_next;
      logic [WIDTH-1:0] s_next;
      logic             ov_r;

      // Final segment: overflow detection and optional saturation.
      always_comb begin
        ov_next = 1'b0;
        s_next  = s_cat;
        // Carry into the MSB recovered as a ^ b ^ sum at that bit.
        ov_next = sl[SW] ^ (a_in[SW-1] ^ b_in[SW-1] ^ sl[SW-1]);
`ifdef ADDSUB_SAT_EN
        if (ov_next) begin
          if (a_in[SW-1]) begin
            s_next = {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            s_next = {1'b0, {(WIDTH-1){1'b1}}};
          end
        end else begin
          s_next = s_cat;
        end
`endif
      end

      // Output stage register: drives Sum, Ovfl and out_valid directly.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_r  <= '0;
          ov_r <= 1'b0;
          v_r  <= 1'b0;
        end else if (advance) begin
          s_r  <= s_next;
          ov_r <= ov_next;
          v_r  <= v_in;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign Sum       = g_stage[STAGES-1].s_r;
  assign Ovfl      = g_stage[STAGES-1].g_last.ov_r;

  // Sticky overflow: set on an accepted overflow result, which beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_sticky <= 1'b0;
    end else if (out_valid && out_ready && Ovfl) begin
      ovfl_sticky <= 1'b1;
    end else if (ovfl_clr) begin
      ovfl_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_sat_addsub_pipe
//
// Directed self-checking bench for sat_addsub_pipe (WIDTH=16, STAGES=2).
// Expected values are hand-computed. Build-dependent results are selected
// with ADDSUB_SAT_EN.
// -----------------------------------------------------------------------------
module tb_sat_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Ovfl;
  logic        ovfl_sticky;
  logic        ovfl_clr;

  int checks = 0;
  int errors = 0;

  sat_addsub_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .Sub         (Sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Sum         (Sum),
    .Ovfl        (Ovfl),
    .ovfl_sticky (ovfl_sticky),
    .ovfl_clr    (ovfl_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operand set through an otherwise idle pipe, out_ready held at 1.
  // The result must appear exactly two cycles after acceptance.
  // clr drives ovfl_clr during the cycle in which the result is consumed.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] exp_sum, input logic exp_ov,
                         input logic clr);
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    Sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_sum"}, {16'd0, Sum}, {16'd0, exp_sum});
    check_eq({tag, "_ovfl"}, {31'd0, Ovfl}, {31'd0, exp_ov});
    ovfl_clr = clr;
    @(posedge clk); #1;
    ovfl_clr = 1'b0;
    check_eq({tag, "_bubble"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Backpressure vectors and their expected results.
  logic [15:0] bp_a   [4] = '{16'h0001, 16'h1000, 16'h7000, 16'hABCD};
  logic [15:0] bp_b   [4] = '{16'h0002, 16'h0001, 16'h7000, 16'h1111};
  logic        bp_s   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
  logic [15:0] bp_exp [4] = '{16'h0003, 16'h0FFF, 16'h7FFF, 16'hBCDE};
`else
  logic [15:0] bp_exp [4] = '{16'h0003, 16'h0FFF, 16'hE000, 16'hBCDE};
`endif
  logic        bp_ov  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int stall;
    logic acc_in;
    logic acc_out;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    A         = 16'h0000;
    B         = 16'h0000;
    Sub       = 1'b0;
    out_ready = 1'b1;
    ovfl_clr  = 1'b0;
    #2 rst_n  = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_sum", {16'd0, Sum}, 32'd0);
    check_eq("rst_ovfl", {31'd0, Ovfl}, 32'd0);
    check_eq("rst_sticky", {31'd0, ovfl_sticky}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic vectors
    run_one("add_5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_one("sub_1022", 16'h1234, 16'h0212, 1'b1, 16'h1022, 1'b0, 1'b0);
    run_one("carry_seg", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_one("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("sticky_still_0", {31'd0, ovfl_sticky}, 32'd0);

`ifdef ADDSUB_SAT_EN
    run_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
`else
    run_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0);
`endif
    check_eq("sticky_set", {31'd0, ovfl_sticky}, 32'd1);

    ovfl_clr = 1'b1;
    @(posedge clk); #1;
    ovfl_clr = 1'b0;
    check_eq("sticky_cleared", {31'd0, ovfl_sticky}, 32'd0);

    // Clear in the same cycle as an accepted overflow result: set wins.
`ifdef ADDSUB_SAT_EN
    run_one("neg_ovf", 16'h8000, 16'h8001, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
    run_one("neg_ovf", 16'h8000, 16'h8001, 1'b0, 16'h0001, 1'b1, 1'b1);
`endif
    check_eq("sticky_set_wins", {31'd0, ovfl_sticky}, 32'd1);

`ifdef ADDSUB_SAT_EN
    run_one("sub_minneg", 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    run_one("sub_neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0);
`else
    run_one("sub_minneg", 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0);
    run_one("sub_neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0);
`endif

    // Backpressure: four back-to-back sets, out_ready low for 3 valid cycles.
    sent  = 0;
    got   = 0;
    stall = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) begin
        in_valid = 1'b1;
        A = bp_a[sent];
        B = bp_b[sent];
        Sub = bp_s[sent];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stall >= 3);
      #1;
      if (out_valid && !out_ready) begin
        stall++;
        check_eq("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check_eq("bp_hold_sum", {16'd0, Sum}, {16'd0, bp_exp[got]});
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        check_eq($sformatf("bp_sum%0d", got), {16'd0, Sum}, {16'd0, bp_exp[got]});
        check_eq($sformatf("bp_ovfl%0d", got), {31'd0, Ovfl}, {31'd0, bp_ov[got]});
        got++;
      end
      @(posedge clk); #1;
      if (acc_in) sent++;
    end
    in_valid = 1'b0;
    check_eq("bp_count", got, 32'd4);
    check_eq("bp_stall_cycles", stall, 32'd3);
    @(posedge clk); #1;
    check_eq("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Reset with two operand sets in flight.
    out_ready = 1'b1;
    in_valid = 1'b1;
    A = 16'h1111;
    B = 16'h2222;
    Sub = 1'b0;
    @(posedge clk); #1;
    A = 16'h3333;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_sum", {16'd0, Sum}, 32'd0);
    check_eq("mid_rst_sticky", {31'd0, ovfl_sticky}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("no_stale_%0d", i), {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sat_addsub_pipe.md
SAT_ADDSUB_PIPE -- requirements
Module: sat_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; legal values are multiples of STAGES and at least 4.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth and carry-segment count; legal values are 1 to 4.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: operand set valid.
REQ-006 SHALL have port in_ready  output  1: block accepts an operand set this cycle.
REQ-007 SHALL have port A  input  WIDTH: signed two's-complement operand.
REQ-008 SHALL have port B  input  WIDTH: signed two's-complement operand.
REQ-009 SHALL have port Sub  input  1: 0 computes A+B; 1 computes A-B.
REQ-010 SHALL have port out_valid  output  1: result valid.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-012 SHALL have port Sum  output  WIDTH: result.
REQ-013 SHALL have port Ovfl  output  1: signed overflow occurred on the result currently presented.
REQ-014 SHALL have port ovfl_sticky  output  1: at least one overflow result has been accepted since the last clear.
REQ-015 SHALL have port ovfl_clr  input  1: synchronous clear of ovfl_sticky.

Function
REQ-016 SHALL transfer an operand set when in_valid and in_ready are both 1 on a rising edge, and a result when out_valid and out_ready are both 1.
REQ-017 SHALL define advance = !out_valid | out_ready, drive in_ready = advance, and move every pipeline stage, including the valid bits, only when advance is 1.
REQ-018 SHALL, when advance is 0, hold Sum, Ovfl and out_valid stable and lose no in-flight data.
REQ-019 SHALL implement subtraction as A + ~B with carry-in 1.
REQ-020 SHALL split the add into STAGES slices of WIDTH/STAGES bits, with stage k adding slice k using the registered carry from stage k-1.
REQ-021 SHALL delay not-yet-added operand slices and already-computed sum slices alongside each operand set, so that each result is self-consistent.
REQ-022 SHALL assert out_valid exactly STAGES cycles after acceptance when there is no backpressure; throughput is one result per cycle.
REQ-023 SHALL compute Ovfl as the XOR of the carry into and the carry out of the MSB.
REQ-024 SHALL report Ovfl correctly at every boundary, including A-B with B = most negative value (e.g. 0x0000-0x8000 overflows).
REQ-025 SHALL set ovfl_sticky on any cycle in which out_valid, out_ready and Ovfl are all 1.
REQ-026 SHALL clear ovfl_sticky on ovfl_clr, except that a set condition in the same cycle wins and ovfl_sticky stays 1.
REQ-027 SHALL, for a bubble (in_valid=0 when advance=1), propagate an invalid stage, and out_valid SHALL drop once that bubble reaches the output.

Reset
REQ-028 SHALL, while rst_n=0, force out_valid=0, Sum=0, Ovfl=0, ovfl_sticky=0 and all stage valid bits to 0, regardless of clk.
REQ-029 SHALL discard all in-flight operands when reset is asserted mid-operation; no stale result may appear after release.
REQ-030 SHALL have in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, when ADDSUB_SAT_EN is defined, saturate any overflowing result: positive overflow gives 0x7FF..F and negative overflow gives 0x800..0, with the direction taken from the sign of A.
REQ-032 SHALL, when ADDSUB_SAT_EN is not defined, produce the wrapped two's-complement result; Ovfl and ovfl_sticky behave identically in both builds.

Verification (WIDTH=16, STAGES=2, ADDSUB_SAT_EN defined unless stated; out_ready=1 unless stated)
REQ-033 Bench SHALL cover: A=0x1234, B=0x4321, Sub=0 -> Sum=0x5555, Ovfl=0, out_valid exactly 2 cycles after acceptance.
REQ-034 Bench SHALL cover: A=0x1234, B=0x0212, Sub=1 -> Sum=0x1022, Ovfl=0.
REQ-035 Bench SHALL cover: A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x7FFF, Ovfl=1, ovfl_sticky=1 on the next cycle.
REQ-036 Bench SHALL cover A=0x8000, B=0x8001, Sub=0 in both builds:
- with the macro: Sum=0x8000, Ovfl=1;
- without the macro: Sum=0x0001, Ovfl=1.
REQ-037 Bench SHALL cover backpressure: issue 4 back-to-back operand sets, hold out_ready=0 for 3 cycles -> in_ready=0 while out_valid=1; all 4 results appear in order, unchanged, with none duplicated.
REQ-038 Bench SHALL cover reset: pulse rst_n low with 2 operand sets in flight -> out_valid=0 and no result emitted after release. The same bench SHALL also assert ovfl_clr in the same cycle as an accepted overflow result -> ovfl_sticky=1.
